// File: rtl/data_memo_arbiter.sv
// Two-port round-robin arbiter and sequencer for the data memory.
// Port A is the core load/store stage, port B the debug/DMA port. Each
// granted request gets one memory access cycle and then one response pulse.

package data_memo_pkg;
  typedef logic [31:0] bus_type;
  typedef enum logic {ST_IDLE, ST_ACCESS} state_e;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;
endpackage

module data_memo_arbiter
  import data_memo_pkg::*;
#(
  parameter int unsigned DEPTH          = 32,
  parameter bit          START_PRIORITY = 1'b0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_a,
  input  logic    req_b,
  input  logic    we_a,
  input  logic    we_b,
  input  bus_type addr_a,
  input  bus_type addr_b,
  input  bus_type wdata_a,
  input  bus_type wdata_b,
  output logic    gnt_a,
  output logic    gnt_b,
  output logic    resp_valid_a,
  output logic    resp_valid_b,
  output bus_type resp_rdata_a,
  output bus_type resp_rdata_b,
  output logic    resp_err_a,
  output logic    resp_err_b,
  output bus_type mem_address,
  output bus_type mem_input_data,
  output logic    mem_enable_read,
  output logic    mem_enable_write,
  input  bus_type mem_read_data
);

  localparam port_e START_PORT = port_e'(START_PRIORITY);

  state_e  state_q, state_d;
  port_e   prio_q, prio_d;

  // Latched copy of the granted request; the requester may change its
  // inputs once the grant has been seen.
  port_e   port_q;
  logic    we_q;
  logic    err_q;
  bus_type addr_q;
  bus_type wdata_q;

  logic    resp_valid_a_q, resp_valid_b_q;
  logic    resp_err_a_q, resp_err_b_q;
  bus_type resp_rdata_a_q, resp_rdata_b_q;

  port_e   sel;
  logic    take;
  logic    sel_we;
  bus_type sel_addr;
  bus_type sel_wdata;
  logic    in_access;
  bus_type access_rdata;

  // Port selection, grant and next-state logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case/if tree can leave a value held (no latch).
    state_d = state_q;
    prio_d  = prio_q;
    sel     = PORT_A;
    take    = 1'b0;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Grants are suppressed while reset is held so gnt reads 0 then.
        if (rst_n && (req_a || req_b)) begin
          take = 1'b1;
          if (req_a && req_b) sel = prio_q;
          else if (req_b)     sel = PORT_B;
          else                sel = PORT_A;
          gnt_a   = (sel == PORT_A);
          gnt_b   = (sel == PORT_B);
          prio_d  = (sel == PORT_A) ? PORT_B : PORT_A;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request fields of the selected port.
  always_comb begin
    sel_we    = (sel == PORT_B) ? we_b    : we_a;
    sel_addr  = (sel == PORT_B) ? addr_b  : addr_a;
    sel_wdata = (sel == PORT_B) ? wdata_b : wdata_a;
  end

  // State and priority pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prio_q  <= START_PORT;
    end else begin
      // NOTE: registers take non-blocking assignments so every block
      // samples pre-edge values regardless of evaluation order.
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Capture the granted request; the range check uses the full bus width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the latched datapath is reset as well so a reset mid-access
      // leaves no stale address or data behind for the next access.
      port_q  <= PORT_A;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      port_q  <= sel;
      we_q    <= sel_we;
      err_q   <= (sel_addr >= bus_type'(DEPTH));
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // Memory drive: active only in ACCESS, enables masked by the range error.
  always_comb begin
    in_access        = (state_q == ST_ACCESS);
    mem_address      = in_access ? addr_q  : '0;
    mem_input_data   = in_access ? wdata_q : '0;
    mem_enable_write = in_access && !err_q &&  we_q;
    mem_enable_read  = in_access && !err_q && !we_q;
    access_rdata     = (!we_q && !err_q) ? mem_read_data : '0;
  end

  // One-cycle response pulse to the port that owned the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_a_q <= 1'b0;
      resp_valid_b_q <= 1'b0;
      resp_err_a_q   <= 1'b0;
      resp_err_b_q   <= 1'b0;
      resp_rdata_a_q <= '0;
      resp_rdata_b_q <= '0;
    end else begin
      resp_valid_a_q <= 1'b0;
      resp_valid_b_q <= 1'b0;
      resp_err_a_q   <= 1'b0;
      resp_err_b_q   <= 1'b0;
      resp_rdata_a_q <= '0;
      resp_rdata_b_q <= '0;
      if (state_q == ST_ACCESS) begin
        if (port_q == PORT_A) begin
          resp_valid_a_q <= 1'b1;
          resp_err_a_q   <= err_q;
          resp_rdata_a_q <= access_rdata;
        end else begin
          resp_valid_b_q <= 1'b1;
          resp_err_b_q   <= err_q;
          resp_rdata_b_q <= access_rdata;
        end
      end
    end
  end

  assign resp_valid_a = resp_valid_a_q;
  assign resp_valid_b = resp_valid_b_q;
  assign resp_err_a   = resp_err_a_q;
  assign resp_err_b   = resp_err_b_q;
  assign resp_rdata_a = resp_rdata_a_q;
  assign resp_rdata_b = resp_rdata_b_q;

endmodule

// File: tb/tb_data_memo_arbiter.sv
// Scoreboard bench for data_memo_arbiter: per-port request queues feed a
// handshake driver; a negedge monitor predicts grants from round-robin rules,
// keeps a reference memory and compares memory-side and response outputs.

module tb_data_memo_arbiter;
  import data_memo_pkg::*;

  localparam int DEPTH = 32;
  localparam bit START = 1'b0;

  typedef struct { logic we; bus_type addr; bus_type wdata; } req_t;
  typedef struct { logic err; bus_type rdata; int due; } exp_t;
  typedef struct { logic valid; logic we; logic err; bus_type addr; bus_type wdata; } acc_t;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    req_a, req_b, we_a, we_b;
  bus_type addr_a, addr_b, wdata_a, wdata_b;
  logic    gnt_a, gnt_b, resp_valid_a, resp_valid_b, resp_err_a, resp_err_b;
  bus_type resp_rdata_a, resp_rdata_b;
  bus_type mem_address, mem_input_data, mem_read_data;
  logic    mem_enable_read, mem_enable_write;

  int checks = 0;
  int errors = 0;

  req_t pa[$], pb[$];
  exp_t exp_a[$], exp_b[$];

  bus_type model_mem [DEPTH];
  bus_type tb_mem [DEPTH];
  bit      pref;
  int      cyc;
  acc_t    pend;

  always #5 clk = ~clk;

  data_memo_arbiter #(.DEPTH(DEPTH), .START_PRIORITY(START)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .resp_valid_a(resp_valid_a), .resp_valid_b(resp_valid_b),
    .resp_rdata_a(resp_rdata_a), .resp_rdata_b(resp_rdata_b),
    .resp_err_a(resp_err_a), .resp_err_b(resp_err_b),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .mem_read_data(mem_read_data)
  );

  // Memory model with a 5-bit address decoder, so stray out-of-range
  // writes would alias onto low words and show up in later reads.
  always @(posedge clk)
    if (mem_enable_write) tb_mem[mem_address[4:0]] <= mem_input_data;
  assign mem_read_data = tb_mem[mem_address[4:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no matching event, required one (t=%0t)", name, $time);
  endtask

  task automatic check_resp(input bit p, input logic v, input logic err, input bus_type rd);
    exp_t  e;
    bit    have;
    string tag;
    tag  = p ? "resp_b" : "resp_a";
    have = p ? (exp_b.size() > 0) : (exp_a.size() > 0);
    if (have) e = p ? exp_b[0] : exp_a[0];
    if (v) begin
      if (!have) fail({tag, "_unexpected"});
      else begin
        if (p) void'(exp_b.pop_front()); else void'(exp_a.pop_front());
        check({tag, "_cycle"}, cyc, e.due);
        check({tag, "_err"}, err, e.err);
        check({tag, "_rdata"}, rd, e.rdata);
      end
    end else begin
      check({tag, "_idle"}, {err, rd}, 64'd0);
      if (have && e.due <= cyc) begin
        fail({tag, "_missing"});
        if (p) void'(exp_b.pop_front()); else void'(exp_a.pop_front());
      end
    end
  endtask

  // Monitor and reference model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_gnt_valid", {gnt_a, gnt_b, resp_valid_a, resp_valid_b}, 64'd0);
      exp_a.delete();
      exp_b.delete();
      pend.valid = 1'b0;
      pref = START;
      cyc  = 0;
    end else begin
      logic eg_a, eg_b;
      cyc++;
      if (pend.valid) begin
        check("acc_we", mem_enable_write, pend.we && !pend.err);
        check("acc_re", mem_enable_read, !pend.we && !pend.err);
        check("acc_addr", mem_address, pend.addr);
        check("acc_data", mem_input_data, pend.wdata);
      end else begin
        check("idle_mem_en", {mem_enable_write, mem_enable_read}, 64'd0);
        check("idle_mem_bus", {mem_address, mem_input_data}, 64'd0);
      end
      eg_a = 1'b0;
      eg_b = 1'b0;
      if (!pend.valid) begin
        if (req_a && (!req_b || pref == 1'b0)) eg_a = 1'b1;
        else if (req_b)                        eg_b = 1'b1;
      end
      check("gnt", {gnt_a, gnt_b}, {eg_a, eg_b});
      check_resp(1'b0, resp_valid_a, resp_err_a, resp_rdata_a);
      check_resp(1'b1, resp_valid_b, resp_err_b, resp_rdata_b);
      if (eg_a || eg_b) begin
        exp_t e;
        pend.valid = 1'b1;
        pend.we    = eg_b ? we_b : we_a;
        pend.addr  = eg_b ? addr_b : addr_a;
        pend.wdata = eg_b ? wdata_b : wdata_a;
        pend.err   = (pend.addr >= DEPTH);
        e.err   = pend.err;
        e.due   = cyc + 2;
        e.rdata = '0;
        if (!pend.err) begin
          if (pend.we) model_mem[pend.addr] = pend.wdata;
          else         e.rdata = model_mem[pend.addr];
        end
        if (eg_b) exp_b.push_back(e); else exp_a.push_back(e);
        pref = eg_a ? 1'b1 : 1'b0;
      end else begin
        pend.valid = 1'b0;
      end
    end
  end

  // Handshake driver: present the head of each queue, retire it on gnt.
  always begin
    logic ga, gb;
    @(negedge clk);
    ga = gnt_a;
    gb = gnt_b;
    @(posedge clk);
    #1;
    if (ga && pa.size() > 0) void'(pa.pop_front());
    if (gb && pb.size() > 0) void'(pb.pop_front());
    req_a = (pa.size() > 0);
    if (req_a) begin we_a = pa[0].we; addr_a = pa[0].addr; wdata_a = pa[0].wdata; end
    else       begin addr_a = $urandom; wdata_a = $urandom; end
    req_b = (pb.size() > 0);
    if (req_b) begin we_b = pb[0].we; addr_b = pb[0].addr; wdata_b = pb[0].wdata; end
    else       begin addr_b = $urandom; wdata_b = $urandom; end
  end

  function automatic req_t rand_req();
    req_t r;
    int   k;
    k       = $urandom_range(0, 9);
    r.we    = 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    if (k == 0)      r.addr = 32 + $urandom_range(0, 31);
    else if (k == 1) r.addr = $urandom | 32'h8000_0000;
    else             r.addr = $urandom_range(0, 31);
    return r;
  endfunction

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((pa.size() > 0 || pb.size() > 0 || exp_a.size() > 0 || exp_b.size() > 0 || pend.valid)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail({tag, "_drain_timeout"});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]    = 32'h11 * i;
      model_mem[i] = 32'h11 * i;
    end
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    pend.valid = 1'b0;
    pref = START;
    cyc  = 0;
    repeat (2) @(posedge clk);

    // Contention straight out of reset: A, B, A.
    pa.push_back('{1'b0, 32'd1, 32'd0});
    pa.push_back('{1'b0, 32'd1, 32'd0});
    pb.push_back('{1'b0, 32'd2, 32'd0});
    @(posedge clk);
    #2 rst_n = 1'b1;
    drain("contention");

    // Write then read back on port A.
    pa.push_back('{1'b1, 32'd5, 32'hDEAD_BEEF});
    pa.push_back('{1'b0, 32'd5, 32'd0});
    drain("wr_rd_a");

    // Out-of-range write on B, then confirm word 0 is untouched.
    pb.push_back('{1'b1, 32'd32, 32'h55});
    pa.push_back('{1'b0, 32'd0, 32'd0});
    drain("oor_b");

    // Back-to-back reads on B with req held.
    for (int i = 0; i < 4; i++) pb.push_back('{1'b0, 32'(3 + i), 32'd0});
    drain("b2b_b");

    // Reset during the ACCESS cycle of an A read.
    pa.push_back('{1'b0, 32'd7, 32'hA5A5_A5A5});
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!gnt_a && n < 20);
      if (!gnt_a) fail("rst_mid_gnt_a");
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_gnt", {gnt_a, gnt_b}, 64'd0);
    check("rst_mid_valid", {resp_valid_a, resp_valid_b, resp_err_a, resp_err_b}, 64'd0);
    check("rst_mid_rdata", {resp_rdata_a, resp_rdata_b}, 64'd0);
    check("rst_mid_en", {mem_enable_write, mem_enable_read}, 64'd0);
    check("rst_mid_addr", mem_address, 64'd0);
    check("rst_mid_data", mem_input_data, 64'd0);
    pa.push_back('{1'b0, 32'd9, 32'd0});
    pb.push_back('{1'b0, 32'd10, 32'd0});
    @(posedge clk);
    #2 rst_n = 1'b1;
    drain("post_reset");

    // Randomized traffic on both ports.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (pa.size() < 2 && $urandom_range(0, 2) == 0) pa.push_back(rand_req());
      if (pb.size() < 2 && $urandom_range(0, 2) == 0) pb.push_back(rand_req());
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_memo_arbiter.md
# data_memo_arbiter

Two-port arbiter and sequencer for the 32-entry data memory. It accepts load/store requests from two requesters: port A is the core load/store stage and port B is the debug/DMA port. It grants them round-robin and drives the memory's address, write-data, read-enable and write-enable inputs from registered request state. It returns one response per granted request, with read data, or an error for out-of-range addresses.

## Interface
- DEPTH, 32: number of memory words; legal word addresses are 0..DEPTH-1.
- START_PRIORITY, 0: port holding priority after reset (0 = A, 1 = B).

- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_a / req_b  in  1  request valid; held until the matching gnt is seen.
- we_a / we_b  in  1  1 = write, 0 = read; sampled with req.
- addr_a / addr_b  in  bus_type  word address.
- wdata_a / wdata_b  in  bus_type  write data.
- gnt_a / gnt_b  out  1  request accepted this cycle (combinational, at most one high).
- resp_valid_a / resp_valid_b  out  1  one-cycle response pulse.
- resp_rdata_a / resp_rdata_b  out  bus_type  read data; 0 unless resp_valid is high for a read.
- resp_err_a / resp_err_b  out  1  address out of range; qualifies resp_valid.
- mem_address  out  bus_type  to memory address.
- mem_input_data  out  bus_type  to memory write data.
- mem_enable_read  out  1  to memory read enable.
- mem_enable_write  out  1  to memory write enable.
- mem_read_data  in  bus_type  from memory; combinational read data.

## Operation
- FSM states: IDLE and ACCESS.
- IDLE, no req: stay in IDLE; all memory enables 0.
- IDLE, any req:
  - Select a port: if only one port requests, select it; if both request, select the priority port.
  - Assert that port's gnt.
  - Latch port id, we, addr, wdata and err (err = addr >= DEPTH).
  - Set the priority pointer to the other port.
  - Go to ACCESS.
- ACCESS:
  - Drive mem_address and mem_input_data from the latched values.
  - err = 0: mem_enable_write = we; mem_enable_read = !we.
  - err = 1: both enables 0; the memory is untouched.
  - Register the response for the latched port: resp_valid = 1; resp_err = err; resp_rdata = mem_read_data if (!we && !err), else 0.
  - Go to IDLE unconditionally.
- gnt is asserted only in IDLE, so it is never asserted in ACCESS.
- A requester still holding req in ACCESS waits.
- Memory outputs are 0 whenever the state is IDLE.
- Addresses are compared as full bus_type unsigned values; no wrap or truncation.

## Timing
- Request at cycle N with state IDLE:
  - gnt in cycle N.
  - Memory access in cycle N+1; a write commits at the edge ending N+1.
  - resp_valid in cycle N+2.
- The response cycle is also IDLE, so a new grant can coincide with the previous response.
- Peak throughput: one access every 2 cycles.
- Requester may change or drop req/addr/wdata from cycle N+1 on; the latched copy is used.
- Both ports requesting continuously: grants alternate A, B, A, … (starting per START_PRIORITY). Neither port waits more than one access.
- Reset values, applied immediately on rst_n low regardless of clk:
  - state = IDLE; priority = START_PRIORITY.
  - All gnt, resp_valid, resp_err and memory enables are 0.
  - resp_rdata, mem_address and mem_input_data are 0.
- Reset during ACCESS: the enables drop at once, the write is not guaranteed to commit, and the pending response is discarded (no resp_valid after reset release).
- First grant is possible in the first cycle with rst_n high.

## Test plan
- Write then read, port A:
  - A writes 0xDEADBEEF to addr 5: gnt_a in N, mem_enable_write in N+1, resp_valid_a with err 0 in N+2.
  - A reads addr 5: resp_rdata_a = 0xDEADBEEF.
- Contention:
  - After reset with START_PRIORITY=0, req_a and req_b held high with reads of addrs 1 and 2 (preloaded 0x11, 0x22).
  - Required: gnt_a at cycle 0, gnt_b at cycle 2, gnt_a at cycle 4.
  - Responses carry 0x11 and 0x22 on the correct ports.
- Out of range:
  - B writes 0x55 to addr 32.
  - Required: resp_err_b = 1; mem_enable_write never asserts; addr 0 contents unchanged.
- Back-to-back, single requester:
  - B issues 4 reads with req held and addr changed after each gnt.
  - Required: gnt_b every 2 cycles; 4 resp_valid_b pulses in order; gnt_a never asserts.
- Reset mid-operation:
  - Deassert rst_n during ACCESS of an A read.
  - Required: all outputs 0 within the same cycle; no resp_valid_a after release; next request is served normally with priority = START_PRIORITY.
